// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Stall or flush loads a bubble; a counter of stall bubbles is
// built only when ID_EX_STALL_CNT_EN is defined, otherwise stall_total reads 0.
module id_ex_reg #(
  parameter int unsigned BITS          = 32,
  parameter int unsigned REG_ADDR_LEFT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pipe,
  input  logic                   flush,
  input  logic                   valid_s2,
  input  logic [REG_ADDR_LEFT:0] r1_addr,
  input  logic [REG_ADDR_LEFT:0] r2_addr,
  input  logic [REG_ADDR_LEFT:0] waddr,
  input  logic                   rw,
  input  logic                   sel_mem,
  input  logic [BITS-1:0]        r1_data,
  input  logic [BITS-1:0]        r2_data,
  input  logic [BITS-1:0]        imm,
  input  logic [3:0]             alu_op,
  output logic [REG_ADDR_LEFT:0] r1_addr_s3,
  output logic [REG_ADDR_LEFT:0] r2_addr_s3,
  output logic [REG_ADDR_LEFT:0] waddr_s3,
  output logic                   rw_s3,
  output logic                   sel_mem_s3,
  output logic [BITS-1:0]        r1_data_s3,
  output logic [BITS-1:0]        r2_data_s3,
  output logic [BITS-1:0]        imm_s3,
  output logic [3:0]             alu_op_s3,
  output logic                   valid_s3,
  output logic                   hold_s2,
  output logic [1:0]             bubble_run,
  output logic [31:0]            stall_total
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e state_q;
  logic   bubble;

  assign bubble  = stall_pipe | flush;
  // A flushed instruction is discarded, so it must never be held in s2.
  assign hold_s2 = stall_pipe & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      // Bubble: no register write (rw is active-low), no load, waddr 0 for forwarding.
      r1_addr_s3 <= '0;
      r2_addr_s3 <= '0;
      waddr_s3   <= '0;
      rw_s3      <= 1'b1;
      sel_mem_s3 <= 1'b0;
      r1_data_s3 <= '0;
      r2_data_s3 <= '0;
      imm_s3     <= '0;
      alu_op_s3  <= '0;
      valid_s3   <= 1'b0;
    end else begin
      r1_addr_s3 <= r1_addr;
      r2_addr_s3 <= r2_addr;
      waddr_s3   <= waddr;
      rw_s3      <= rw;
      sel_mem_s3 <= sel_mem;
      r1_data_s3 <= r1_data;
      r2_data_s3 <= r2_data;
      imm_s3     <= imm;
      alu_op_s3  <= alu_op;
      valid_s3   <= valid_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      bubble_run <= 2'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bubble) begin
            state_q    <= StBubble;
            bubble_run <= 2'd1;
          end else begin
            bubble_run <= 2'd0;
          end
        end
        StBubble: begin
          if (bubble) begin
            if (bubble_run != 2'd3) bubble_run <= bubble_run + 2'd1;
          end else begin
            state_q    <= StRun;
            bubble_run <= 2'd0;
          end
        end
        default: begin
          state_q    <= StRun;
          bubble_run <= 2'd0;
        end
      endcase
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_total_q <= '0;
    end else if (stall_pipe && !flush) begin
      stall_total_q <= stall_total_q + 32'd1;
    end
  end

  assign stall_total = stall_total_q;
`else
  assign stall_total = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus pushes the expected s3 state, a monitor pops and
// compares it one cycle later.
module tb_id_ex_reg;

  localparam int unsigned BITS = 32;
  localparam int unsigned RAL  = 4;

  logic            clk = 1'b0;
  logic            rst, stall_pipe, flush, valid_s2, rw, sel_mem;
  logic [RAL:0]    r1_addr, r2_addr, waddr;
  logic [BITS-1:0] r1_data, r2_data, imm;
  logic [3:0]      alu_op;
  logic [RAL:0]    r1_addr_s3, r2_addr_s3, waddr_s3;
  logic            rw_s3, sel_mem_s3, valid_s3, hold_s2;
  logic [BITS-1:0] r1_data_s3, r2_data_s3, imm_s3;
  logic [3:0]      alu_op_s3;
  logic [1:0]      bubble_run;
  logic [31:0]     stall_total;

  id_ex_reg #(.BITS(BITS), .REG_ADDR_LEFT(RAL)) dut (
    .clk(clk), .rst(rst), .stall_pipe(stall_pipe), .flush(flush), .valid_s2(valid_s2),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .waddr(waddr), .rw(rw), .sel_mem(sel_mem),
    .r1_data(r1_data), .r2_data(r2_data), .imm(imm), .alu_op(alu_op),
    .r1_addr_s3(r1_addr_s3), .r2_addr_s3(r2_addr_s3), .waddr_s3(waddr_s3), .rw_s3(rw_s3),
    .sel_mem_s3(sel_mem_s3), .r1_data_s3(r1_data_s3), .r2_data_s3(r2_data_s3),
    .imm_s3(imm_s3), .alu_op_s3(alu_op_s3), .valid_s3(valid_s3), .hold_s2(hold_s2),
    .bubble_run(bubble_run), .stall_total(stall_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RAL:0]    r1a, r2a, wa;
    logic            rw, sm, vld;
    logic [BITS-1:0] r1d, r2d, im;
    logic [3:0]      op;
    logic [1:0]      br;
    logic [31:0]     st;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] exp_st = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle of stimulus; br is the hand-computed bubble_run after the edge.
  task automatic step(input logic r, input logic fl, input logic st, input logic v,
                      input logic [RAL:0] wa, input logic w, input logic [31:0] d,
                      input logic [1:0] br, input logic exp_hold);
    exp_t e;
    logic blank;
    rst = r; flush = fl; stall_pipe = st; valid_s2 = v; waddr = wa; rw = w;
    r1_addr = wa + 5'd1; r2_addr = wa + 5'd2; sel_mem = wa[0]; alu_op = wa[3:0];
    r1_data = d; r2_data = d ^ 32'hA5A5_0000; imm = ~d;
    #1;
    chk("hold_s2", {63'd0, hold_s2}, {63'd0, exp_hold});
    blank = r | fl | st;
`ifdef ID_EX_STALL_CNT_EN
    if (r) exp_st = 0;
    else if (st && !fl) exp_st = exp_st + 1;
`endif
    e.r1a = blank ? '0 : r1_addr;  e.r2a = blank ? '0 : r2_addr;  e.wa = blank ? '0 : wa;
    e.rw  = blank ? 1'b1 : w;      e.sm  = blank ? 1'b0 : sel_mem; e.vld = blank ? 1'b0 : v;
    e.r1d = blank ? '0 : r1_data;  e.r2d = blank ? '0 : r2_data;  e.im = blank ? '0 : imm;
    e.op  = blank ? '0 : alu_op;   e.br = br;                     e.st = exp_st;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_s3",    {63'd0, valid_s3}, {63'd0, e.vld});
        chk("rw_s3",       {63'd0, rw_s3}, {63'd0, e.rw});
        chk("sel_mem_s3",  {63'd0, sel_mem_s3}, {63'd0, e.sm});
        chk("addrs_s3",    {49'd0, r1_addr_s3, r2_addr_s3, waddr_s3}, {49'd0, e.r1a, e.r2a, e.wa});
        chk("r1_data_s3",  {32'd0, r1_data_s3}, {32'd0, e.r1d});
        chk("r2_data_s3",  {32'd0, r2_data_s3}, {32'd0, e.r2d});
        chk("imm_s3",      {32'd0, imm_s3}, {32'd0, e.im});
        chk("alu_op_s3",   {60'd0, alu_op_s3}, {60'd0, e.op});
        chk("bubble_run",  {62'd0, bubble_run}, {62'd0, e.br});
        chk("stall_total", {32'd0, stall_total}, {32'd0, e.st});
      end
    end
  end

  initial begin : stimulus
    @(negedge clk);
    // reset: bubble values
    step(1, 0, 0, 1, 5'd9, 0, 32'hDEAD_BEEF, 2'd0, 0);
    // normal load
    step(0, 0, 0, 1, 5'd5, 0, 32'h0000_1234, 2'd0, 0);
    // load-use: one bubble, then the held instruction loads
    step(0, 0, 1, 1, 5'd7, 0, 32'h0000_7777, 2'd1, 1);
    step(0, 0, 0, 1, 5'd7, 0, 32'h0000_7777, 2'd0, 0);
    // two-cycle stall, then load with rw=1
    step(0, 0, 1, 1, 5'd12, 1, 32'hCAFE_0001, 2'd1, 1);
    step(0, 0, 1, 1, 5'd12, 1, 32'hCAFE_0001, 2'd2, 1);
    step(0, 0, 0, 1, 5'd12, 1, 32'hCAFE_0001, 2'd0, 0);
    // flush+stall: not held, not counted; then plain flush continues the run
    step(0, 1, 1, 1, 5'd3, 0, 32'h1111_2222, 2'd1, 0);
    step(0, 1, 0, 1, 5'd4, 0, 32'h3333_4444, 2'd2, 0);
    // valid_s2=0 without stall is a normal load
    step(0, 0, 0, 0, 5'd31, 0, 32'h8000_0001, 2'd0, 0);
    // five-cycle stall saturates at 3
    step(0, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd1, 1);
    step(0, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd2, 1);
    step(0, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd3, 1);
    step(0, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd3, 1);
    step(0, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd3, 1);
    // reset mid-stall overrides everything
    step(1, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd0, 0);
    step(0, 0, 1, 1, 5'd6, 0, 32'h0606_0606, 2'd1, 1);
    step(0, 0, 0, 1, 5'd6, 0, 32'h0606_0606, 2'd0, 0);
    step(0, 0, 0, 1, 5'd10, 0, 32'hFFFF_FFFF, 2'd0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
